// File: rtl/mxint_cast.sv
// MXINT requantiser: renormalises a block of wide accumulated mantissas with a
// shared exponent into a narrow MXINT block through a two-stage valid/ready pipeline.
module mxint_cast #(
  parameter int IN_MAN_W   = 28,
  parameter int IN_EXP_W   = 4,
  parameter int OUT_MAN_W  = 8,
  parameter int OUT_EXP_W  = 4,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [IN_MAN_W*BLOCK_SIZE-1:0]  mdata_in_0,
  input  logic [IN_EXP_W-1:0]             edata_in_0,
  input  logic                            data_in_0_valid,
  output logic                            data_in_0_ready,
  output logic [OUT_MAN_W*BLOCK_SIZE-1:0] mdata_out_0,
  output logic [OUT_EXP_W-1:0]            edata_out_0,
  output logic                            data_out_0_valid,
  input  logic                            data_out_0_ready
);

  localparam int SHIFT_W = $clog2(IN_MAN_W + 1);
  // Exponent sum is kept wide enough for the largest possible shift, so the
  // overflow test can never wrap even when the shift exceeds the exponent range.
  localparam int EXP_W = ((OUT_EXP_W > SHIFT_W) ? OUT_EXP_W : SHIFT_W) + 2;

  localparam logic [SHIFT_W-1:0]         OUT_W_S = SHIFT_W'(OUT_MAN_W);
  localparam logic signed [IN_MAN_W:0]   MAN_HI  = (IN_MAN_W+1)'(2**(OUT_MAN_W-1) - 1);
  localparam logic signed [IN_MAN_W:0]   MAN_LO  = (IN_MAN_W+1)'(-(2**(OUT_MAN_W-1)));
  localparam logic signed [EXP_W-1:0]    EXP_MAX = EXP_W'(2**(OUT_EXP_W-1) - 1);
  localparam logic [OUT_MAN_W-1:0]       SAT_POS = OUT_MAN_W'(2**(OUT_MAN_W-1) - 1);
  localparam logic [OUT_MAN_W-1:0]       SAT_NEG = OUT_MAN_W'(-(2**(OUT_MAN_W-1) - 1));
  localparam logic [OUT_MAN_W-1:0]       SAT_MIN = OUT_MAN_W'(-(2**(OUT_MAN_W-1)));

  // Minimum two's-complement width from the magnitude pattern (m or ~m).
  function automatic logic [SHIFT_W-1:0] sig_width(input logic [IN_MAN_W-1:0] mag);
    sig_width = SHIFT_W'(1);
    for (int b = 0; b < IN_MAN_W; b++)
      if (mag[b]) sig_width = SHIFT_W'(b + 2);
  endfunction

  function automatic logic signed [IN_MAN_W:0] round_shift(
    input logic signed [IN_MAN_W-1:0] m,
    input logic [SHIFT_W-1:0]         sh
  );
    logic signed [IN_MAN_W:0] ext;
    logic signed [IN_MAN_W:0] half;
    ext  = {m[IN_MAN_W-1], m};
    half = (IN_MAN_W+1)'(1) <<< (sh - SHIFT_W'(1));
    round_shift = (sh == '0) ? ext : ((ext + half) >>> sh);
  endfunction

  function automatic logic [OUT_MAN_W-1:0] saturate(input logic signed [IN_MAN_W:0] r);
    if (r > MAN_HI)
      saturate = SAT_POS;
    else if (r < MAN_LO)
      saturate = SAT_MIN;
    else
      saturate = r[OUT_MAN_W-1:0];
  endfunction

  logic                           vld_p1;
  logic [IN_MAN_W*BLOCK_SIZE-1:0] man_p1;
  logic signed [IN_EXP_W-1:0]     exp_p1;
  logic [SHIFT_W-1:0]             shift_p1;

  logic                            vld_p2;
  logic [OUT_MAN_W*BLOCK_SIZE-1:0] man_p2;
  logic [OUT_EXP_W-1:0]            exp_p2;

  logic ld_p1;
  logic ld_p2;

  assign ld_p2           = vld_p1 && (!vld_p2 || data_out_0_ready);
  assign data_in_0_ready = !vld_p1 || ld_p2;
  assign ld_p1           = data_in_0_valid && data_in_0_ready;

  // ---- stage 1: block-wide width detect ----
  logic [IN_MAN_W-1:0] elem_p0;
  logic [IN_MAN_W-1:0] mag_or_p0;
  logic [SHIFT_W-1:0]  width_p0;
  logic [SHIFT_W-1:0]  shift_p0;

  always_comb begin
    elem_p0   = '0;
    mag_or_p0 = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      elem_p0   = mdata_in_0[i*IN_MAN_W +: IN_MAN_W];
      mag_or_p0 = mag_or_p0 | (elem_p0[IN_MAN_W-1] ? ~elem_p0 : elem_p0);
    end
    width_p0 = sig_width(mag_or_p0);
    shift_p0 = (width_p0 > OUT_W_S) ? (width_p0 - OUT_W_S) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      vld_p1 <= 1'b0;
    else if (ld_p1)
      vld_p1 <= 1'b1;
    else if (ld_p2)
      vld_p1 <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (ld_p1) begin
      man_p1   <= mdata_in_0;
      exp_p1   <= edata_in_0;
      shift_p1 <= shift_p0;
    end
  end

  // ---- stage 2: shift, round, saturate, exponent update ----
  logic signed [EXP_W-1:0]         exp_sum_p1;
  logic                            exp_ovf_p1;
  logic signed [IN_MAN_W-1:0]      m_p1;
  logic signed [IN_MAN_W:0]        r_p1;
  logic [OUT_MAN_W*BLOCK_SIZE-1:0] man_nxt_p1;
  logic [OUT_EXP_W-1:0]            exp_nxt_p1;

  always_comb begin
    exp_sum_p1 = EXP_W'(exp_p1) + $signed(EXP_W'(shift_p1));
    exp_ovf_p1 = exp_sum_p1 > EXP_MAX;
    exp_nxt_p1 = exp_ovf_p1 ? OUT_EXP_W'(EXP_MAX) : exp_sum_p1[OUT_EXP_W-1:0];
    m_p1       = '0;
    r_p1       = '0;
    man_nxt_p1 = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      m_p1 = man_p1[i*IN_MAN_W +: IN_MAN_W];
      r_p1 = round_shift(m_p1, shift_p1);
      // On exponent overflow the element's own sign decides, not its rounded value.
      if (exp_ovf_p1)
        man_nxt_p1[i*OUT_MAN_W +: OUT_MAN_W] =
          (m_p1 == '0) ? '0 : (m_p1[IN_MAN_W-1] ? SAT_NEG : SAT_POS);
      else
        man_nxt_p1[i*OUT_MAN_W +: OUT_MAN_W] = saturate(r_p1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      man_p2 <= '0;
      exp_p2 <= '0;
    end else if (ld_p2) begin
      vld_p2 <= 1'b1;
      man_p2 <= man_nxt_p1;
      exp_p2 <= exp_nxt_p1;
    end else if (data_out_0_ready) begin
      vld_p2 <= 1'b0;
    end
  end

  assign data_out_0_valid = vld_p2;
  assign mdata_out_0      = man_p2;
  assign edata_out_0      = exp_p2;

endmodule

// File: tb/tb_mxint_cast.sv
// Scoreboard bench for mxint_cast: directed blocks with hand-computed results,
// mid-stream reset and a backpressured stream.
module tb_mxint_cast;
  localparam int IMW = 28;
  localparam int IEW = 4;
  localparam int OMW = 8;
  localparam int OEW = 4;
  localparam int BS  = 4;
  localparam int OUT_BITS = BS*OMW + OEW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [BS*IMW-1:0] mdata_in_0 = '0;
  logic [IEW-1:0]    edata_in_0 = '0;
  logic              data_in_0_valid = 1'b0;
  logic              data_in_0_ready;
  logic [BS*OMW-1:0] mdata_out_0;
  logic [OEW-1:0]    edata_out_0;
  logic              data_out_0_valid;
  logic              data_out_0_ready = 1'b1;

  mxint_cast #(
    .IN_MAN_W(IMW), .IN_EXP_W(IEW), .OUT_MAN_W(OMW), .OUT_EXP_W(OEW), .BLOCK_SIZE(BS)
  ) dut (
    .clk(clk), .rst(rst),
    .mdata_in_0(mdata_in_0), .edata_in_0(edata_in_0),
    .data_in_0_valid(data_in_0_valid), .data_in_0_ready(data_in_0_ready),
    .mdata_out_0(mdata_out_0), .edata_out_0(edata_out_0),
    .data_out_0_valid(data_out_0_valid), .data_out_0_ready(data_out_0_ready)
  );

  always #5 clk = ~clk;

  logic [OUT_BITS-1:0] sb[$];
  int  applied = 0;
  int  miscompares = 0;
  int  inflight = 0;
  bit  rand_mode = 1'b0;
  bit  ready_fixed = 1'b1;
  bit  held = 1'b0;
  logic [OUT_BITS-1:0] held_val;
  logic [OUT_BITS-1:0] exp_blk;

  function automatic logic [BS*IMW-1:0] pack_in(int a, int b, int c, int d);
    return {IMW'(d), IMW'(c), IMW'(b), IMW'(a)};
  endfunction

  function automatic logic [OUT_BITS-1:0] pack_out(int a, int b, int c, int d, int e);
    return {OEW'(e), OMW'(d), OMW'(c), OMW'(b), OMW'(a)};
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Downstream ready, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    data_out_0_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // Blocks held inside the DUT, tracked from handshakes.
  always @(posedge clk) begin
    if (rst)
      inflight = 0;
    else
      inflight = inflight + ((data_in_0_valid && data_in_0_ready) ? 1 : 0)
                          - ((data_out_0_valid && data_out_0_ready) ? 1 : 0);
  end

  // Monitor.
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      check("in_ready", 64'(data_in_0_ready), 64'(!(inflight == 2 && !data_out_0_ready)));
      if (held) begin
        check("stall_valid", 64'(data_out_0_valid), 64'(1));
        check("stall_data", 64'({edata_out_0, mdata_out_0}), 64'(held_val));
      end
      if (data_out_0_valid && data_out_0_ready) begin
        if (sb.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL unexpected_output: got %0h, expected no block at %0t",
                   {edata_out_0, mdata_out_0}, $time);
        end else begin
          exp_blk = sb.pop_front();
          check("block", 64'({edata_out_0, mdata_out_0}), 64'(exp_blk));
        end
      end
      held     = data_out_0_valid && !data_out_0_ready;
      held_val = {edata_out_0, mdata_out_0};
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(int a, int b, int c, int d, int e,
                      int ra, int rb, int rc, int rd, int re);
    int waited;
    waited = 0;
    mdata_in_0      = pack_in(a, b, c, d);
    edata_in_0      = IEW'(e);
    data_in_0_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (data_in_0_ready) begin
        sb.push_back(pack_out(ra, rb, rc, rd, re));
        break;
      end
      waited++;
      if (waited > 1000) begin
        applied++;
        miscompares++;
        $display("FAIL send_timeout: got ready=0 for %0d cycles, expected acceptance", waited);
        data_in_0_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    data_in_0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      applied++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d blocks pending, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 64'(data_out_0_valid), 64'(0));
    check("rst_mdata", 64'(mdata_out_0), 64'(0));
    check("rst_edata", 64'(edata_out_0), 64'(0));
    check("rst_ready", 64'(data_in_0_ready), 64'(1));

    // Basic shift with explicit two-cycle latency.
    send(1000, -3, 0, 5, 0,     125, 0, 0, 1, 3);
    @(posedge clk);
    #1;
    check("lat_valid", 64'(data_out_0_valid), 64'(1));
    check("lat_data", 64'({edata_out_0, mdata_out_0}), 64'(pack_out(125, 0, 0, 1, 3)));

    send(127, -128, 1, -1, -2,  127, -128, 1, -1, -2);
    send(0, 0, 0, 0, 5,         0, 0, 0, 0, 5);
    send(255, 0, 0, 0, 0,       127, 0, 0, 0, 1);
    send(-256, 0, 0, 0, 0,      -128, 0, 0, 0, 1);
    send(1000, -1000, 0, 2, 6,  127, -127, 0, 127, 7);
    wait_drain();

    // Fill both stages against a stalled sink, then reset.
    ready_fixed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(10, 20, 30, 40, 0,     10, 20, 30, 40, 0);
    send(-5, 6, -7, 8, 1,       -5, 6, -7, 8, 1);
    check("full_valid", 64'(data_out_0_valid), 64'(1));
    check("full_ready", 64'(data_in_0_ready), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    check("mid_rst_valid", 64'(data_out_0_valid), 64'(0));
    check("mid_rst_mdata", 64'(mdata_out_0), 64'(0));
    check("mid_rst_edata", 64'(edata_out_0), 64'(0));
    ready_fixed = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(data_out_0_valid), 64'(0));
    send(3, -4, 100, -100, -1,  3, -4, 100, -100, -1);
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(data_out_0_valid), 64'(1));
    check("post_rst_data", 64'({edata_out_0, mdata_out_0}), 64'(pack_out(3, -4, 100, -100, -1)));
    wait_drain();

    // Backpressured stream of eight distinct blocks.
    rand_mode = 1'b1;
    send(64, -64, 3, -5, 1,               64, -64, 3, -5, 1);
    send(200, 0, 0, 0, -1,                100, 0, 0, 0, 0);
    send(-1, 1, 0, -1, 7,                 -1, 1, 0, -1, 7);
    send(4096, -4097, 17, -9, -4,         64, -64, 0, 0, 2);
    send(300, -300, 150, -150, -3,        75, -75, 38, -37, -1);
    send(-128, -128, -128, -128, 0,       -128, -128, -128, -128, 0);
    send(-67108864, 5, -5, 0, -8,         -127, 127, -127, 0, 7);
    send(1023, 511, -512, 2, 3,           127, 64, -64, 0, 6);
    wait_drain();
    rand_mode = 1'b0;
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
